cpc_printer_port: RTL and testbench

//  Peripheral-side responder for the CPC Centronics printer port: decodes CPU I/O writes
//  (A12=0), tracks the STROBE bit and captures each strobed 7-bit byte into a FIFO

---
 rtl/cpc_printer_port.sv | 113 +++++++++++
 tb/tb_cpc_printer_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpc_printer_port.sv
// CPC Centronics printer port responder: latches the port on each I/O write, captures strobed bytes
// into a first-word-fall-through FIFO and drives a registered BUSY handshake back to the PPI.
module cpc_printer_port #(
    parameter int DEPTH      = 16,
    parameter int BUSY_TICKS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_4p,
    input  logic [15:0]              cpu_addr,
    input  logic [7:0]               cpu_dout,
    input  logic                     io_wr,
    output logic                     busy,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);
    localparam logic [7:0]  RELOAD     = 8'(BUSY_TICKS);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state;
    logic [7:0]      cnt;
    logic            io_wr_q;
    logic [7:0]      port_reg;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [6:0]      mem [DEPTH];

    logic wr_edge;
    logic capture;
    logic full;
    logic pop;
    logic push;

    // One latch per bus cycle: only the first clk of a long io_wr pulse counts.
    assign wr_edge   = io_wr & ~cpu_addr[12] & ~io_wr_q;
    assign capture   = wr_edge & ~port_reg[7] & cpu_dout[7];
    assign full      = (level == FULL_LEVEL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign push      = capture & (~full | pop);
    assign out_data  = out_valid ? {1'b0, mem[rd_ptr]} : 8'h00;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= cpu_dout[6:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_wr_q  <= 1'b0;
            port_reg <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
            cnt      <= 8'h00;
        end else begin
            io_wr_q <= io_wr;
            if (wr_edge)
                port_reg <= cpu_dout;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                level <= level + 1'b1;
            else if (pop & ~push)
                level <= level - 1'b1;

            if (capture & ~push)
                overflow <= 1'b1;

            // BUSY trails the FSM by one clk and also covers a full FIFO.
            busy <= (state == HOLD) | full;

            case (state)
                IDLE: begin
                    if (capture) begin
                        state <= HOLD;
                        cnt   <= RELOAD;
                    end
                end
                HOLD: begin
                    if (capture) begin
                        cnt <= RELOAD;
                    end else if (ce_4p) begin
                        if (cnt == 8'd1) begin
                            state <= IDLE;
                            cnt   <= 8'h00;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpc_printer_port.sv
// Randomized self-checking bench for cpc_printer_port against a queue-based printer model,
// plus directed scenarios for write detection, BUSY hold, FIFO full/overflow and reset.
module tb_cpc_printer_port;

    localparam int DEPTH      = 16;
    localparam int BUSY_TICKS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_4p = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        io_wr = 1'b0;
    logic        busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  level;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_rdy = 0;

    // Behavioural model: printer port register, byte queue, hold ticks left, sticky overflow.
    logic [7:0] m_port;
    logic       m_wr_prev;
    logic [6:0] m_q[$];
    logic       m_ovf;
    int         m_hold;
    logic       m_busy;

    cpc_printer_port #(.DEPTH(DEPTH), .BUSY_TICKS(BUSY_TICKS)) dut (
        .clk(clk), .reset(reset), .ce_4p(ce_4p), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .io_wr(io_wr), .busy(busy), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep();
        bit busy_next, pop, wr_hit, cap, was_full;
        if (reset) begin
            m_port = 8'h00; m_wr_prev = 1'b0; m_q.delete(); m_ovf = 1'b0;
            m_hold = 0; m_busy = 1'b0;
            return;
        end
        busy_next = (m_hold > 0) || (m_q.size() == DEPTH);
        was_full  = (m_q.size() == DEPTH);
        pop       = (m_q.size() > 0) && out_ready;
        wr_hit    = io_wr && !cpu_addr[12] && !m_wr_prev;
        cap       = wr_hit && !m_port[7] && cpu_dout[7];
        if (wr_hit) m_port = cpu_dout;
        if (cap) m_hold = BUSY_TICKS;
        else if (m_hold > 0 && ce_4p) m_hold--;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (!was_full || pop) m_q.push_back(cpu_dout[6:0]);
            else m_ovf = 1'b1;
        end
        m_wr_prev = io_wr;
        m_busy = busy_next;
    endtask

    task automatic compareAll();
        logic [7:0] exp_data;
        exp_data = (m_q.size() > 0) ? {1'b0, m_q[0]} : 8'h00;
        checkOutput("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        checkOutput("out_data", 32'(out_data), 32'(exp_data));
        checkOutput("level", 32'(level), 32'(m_q.size()));
        checkOutput("busy", 32'(busy), 32'(m_busy));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic wr,
                                 input logic rdy, input logic rst);
        cpu_addr  = a;
        cpu_dout  = d;
        io_wr     = wr;
        out_ready = rand_rdy ? 1'($urandom % 2) : rdy;
        reset     = rst;
        ce_4p     = (cyc % 3 == 2);
        cyc++;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(16'h0000, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [7:0] d, input int clks);
        for (int i = 0; i < clks; i++) applyStimulus(a, d, 1'b1, 1'b0, 1'b0);
        applyStimulus(a, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobeByte(input logic [6:0] d);
        doWrite(16'hEF00, 8'h00, 1);
        doWrite(16'hEF00, {1'b1, d}, 1);
    endtask

    task automatic doReset();
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic waitBusyLow(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            idle(1, 1'b0);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_level", 32'(level), 32'd0);
        checkOutput("t1_ovf", 32'(overflow), 32'd0);

        // Single capture and BUSY hold
        doWrite(16'hEF00, 8'h41, 2);
        doWrite(16'hEF00, 8'hC1, 2);
        doWrite(16'hEF00, 8'h41, 2);
        checkOutput("t2_level", 32'(level), 32'd1);
        checkOutput("t2_data", 32'(out_data), 32'h41);
        checkOutput("t2_busy_on", 32'(busy), 32'd1);
        waitBusyLow("t2_busy_off");

        // Long io_wr pulse and A12=1 decode
        doReset();
        doWrite(16'hEF00, 8'hA2, 10);
        checkOutput("t3_one_capture", 32'(level), 32'd1);
        doWrite(16'hEF00, 8'h00, 1);
        doWrite(16'h7F00, 8'hC5, 3);
        checkOutput("t3_a12_ignored", 32'(level), 32'd1);
        doWrite(16'hEF00, 8'hB3, 1);
        checkOutput("t3_port_kept", 32'(level), 32'd2);
        checkOutput("t3_head", 32'(out_data), 32'h22);

        // Fill, overflow, pop releases BUSY
        doReset();
        for (int i = 0; i < DEPTH; i++) strobeByte(7'(i + 16));
        checkOutput("t4_full", 32'(level), 32'd16);
        idle(40, 1'b0);
        checkOutput("t4_busy_full", 32'(busy), 32'd1);
        strobeByte(7'h7E);
        checkOutput("t4_ovf", 32'(overflow), 32'd1);
        checkOutput("t4_level_kept", 32'(level), 32'd16);
        idle(40, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        checkOutput("t4_level_pop", 32'(level), 32'd15);
        checkOutput("t4_busy_fall", 32'(busy), 32'd0);

        // Full FIFO with capture and pop in the same clk
        doReset();
        for (int i = 0; i < DEPTH; i++) strobeByte(7'(i + 32));
        doWrite(16'hEF00, 8'h00, 1);
        applyStimulus(16'hEF00, 8'hD5, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'hEF00, 8'hD5, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_level", 32'(level), 32'd16);
        checkOutput("t5_ovf", 32'(overflow), 32'd0);
        idle(20, 1'b1);
        checkOutput("t5_drained", 32'(level), 32'd0);

        // Reset during HOLD with entries pending
        for (int i = 0; i < 3; i++) strobeByte(7'(i + 5));
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_level", 32'(level), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        strobeByte(7'h2A);
        checkOutput("t6_after", 32'(out_data), 32'h2A);
        waitBusyLow("t6_busy_off");

        // Randomized traffic
        rand_rdy = 1;
        for (int it = 0; it < 400; it++) begin
            int op;
            logic [15:0] a;
            op = int'($urandom % 20);
            a  = 16'($urandom);
            if ($urandom % 4 != 0) a[12] = 1'b0;
            if (op == 0) doReset();
            else if (op < 12) doWrite(a, 8'($urandom), 1 + int'($urandom % 4));
            else idle(1 + int'($urandom % 6), 1'b0);
        end
        rand_rdy = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
